sp_command_dispatcher: RTL

//  Sequencing controller behind the service-protocol unpacker.
//  - Collects the unpacked data words of one packet into a local buffer.
//  - Filters packets by module address and command code.
//  - Commits a packet only on packet end with good CRC; discards it on packet error or overflow.
//  - Replays a committed packet to the command executor as one header beat plus a data-word stream.

---
 rtl/sp_command_dispatcher_pkg.sv | 34 +++
 rtl/sp_command_dispatcher_buffer.sv | 25 ++
 rtl/sp_command_dispatcher.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_command_dispatcher_pkg.sv
// Service-protocol shared types: command codes, dispatcher states and the
// helper functions used by the dispatcher.
package ServiceProtocol;

  localparam int unsigned SP_WORD_W = 16;
  localparam int unsigned SP_LEN_W  = 9;
  localparam int unsigned SP_ADDR_W = 8;

  localparam logic [SP_ADDR_W-1:0] SP_BROADCAST_ADDR = 8'hFF;

  typedef enum logic [7:0] {
    TCC_UNKNOWN   = 8'h00,
    TCC_READ_REG  = 8'h01,
    TCC_WRITE_REG = 8'h02,
    TCC_FW_CHUNK  = 8'h10,
    TCC_SOFT_RST  = 8'h7F
  } TCommandCode;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DROP,
    DISPATCH_HDR,
    DISPATCH_DATA
  } TDispatchState;

  // True when a packet header targets this module and carries a known command.
  function automatic logic isAccepted(input logic [SP_ADDR_W-1:0] addr,
                                      input logic [SP_ADDR_W-1:0] ownAddr,
                                      input TCommandCode cmd);
    return ((addr == ownAddr) || (addr == SP_BROADCAST_ADDR)) && (cmd != TCC_UNKNOWN);
  endfunction

endpackage

// File: rtl/sp_command_dispatcher_buffer.sv
// Packet word store for the command dispatcher: DEPTH x W register array with
// one synchronous write port and one combinational read port.
module sp_dispatch_buffer
  import ServiceProtocol::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = SP_WORD_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [W-1:0]             wrData,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [W-1:0]             rdData
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/sp_command_dispatcher.sv
// Service-protocol command dispatcher: buffers, filters, commits and replays
// packets. Optional packet statistics are built under SP_DISPATCH_STATS_EN.
module sp_command_dispatcher
  import ServiceProtocol::*;
#(
  parameter logic [SP_ADDR_W-1:0] MODULE_ADDR = 8'h01,
  parameter int unsigned          DEPTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_request,
  input  logic [SP_WORD_W-1:0] in_data,
  output logic                 in_done,
  input  logic                 pkt_start,
  input  logic                 pkt_end,
  input  logic                 pkt_err,
  input  logic [SP_ADDR_W-1:0] pkt_addr,
  input  TCommandCode          pkt_cmd,
  output logic                 rx_hold,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output TCommandCode          cmd_code,
  output logic [SP_LEN_W-1:0]  cmd_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SP_WORD_W-1:0] out_data,
  output logic                 out_last,
  output logic [15:0]          stat_ok,
  output logic [15:0]          stat_err,
  output logic [15:0]          stat_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = SP_LEN_W;

  TDispatchState        state;
  logic [PW-1:0]        wrPtr;
  logic [PW-1:0]        rdPtr;
  logic                 ovf;
  logic [LW-1:0]        cmdLen;
  TCommandCode          cmdCode;
  logic                 cmdValid;
  logic                 outValid;
  logic                 rxHold;
  logic                 inDone;

  logic                 accept;
  logic                 wrFits;
  logic                 storeWord;
  logic                 collectOvf;
  logic [LW-1:0]        collectLen;
  logic                 lastBeat;
  logic                 bufWe;
  logic [AW-1:0]        bufWrAddr;
  logic [SP_WORD_W-1:0] rdData;

  // Decode helpers shared by the FSM and the buffer write port.
  always_comb begin
    accept     = isAccepted(pkt_addr, MODULE_ADDR, pkt_cmd);
    wrFits     = wrPtr < PW'(DEPTH);
    storeWord  = in_request && wrFits;
    collectOvf = ovf || (in_request && !wrFits);
    collectLen = LW'(wrPtr) + LW'(storeWord);
    lastBeat   = LW'(rdPtr) == (cmdLen - LW'(1));
    bufWe      = 1'b0;
    bufWrAddr  = wrPtr[AW-1:0];
    if (state == COLLECT) begin
      bufWe = storeWord;
    end else if (state == IDLE) begin
      bufWe     = pkt_start && accept && !pkt_err && in_request;
      bufWrAddr = '0;
    end
  end

  sp_dispatch_buffer #(
    .DEPTH (DEPTH),
    .W     (SP_WORD_W)
  ) u_buffer (
    .clk    (clk),
    .we     (bufWe),
    .wrAddr (bufWrAddr),
    .wrData (in_data),
    .rdAddr (rdPtr[AW-1:0]),
    .rdData (rdData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wrPtr    <= '0;
      rdPtr    <= '0;
      ovf      <= 1'b0;
      cmdLen   <= '0;
      cmdCode  <= TCC_UNKNOWN;
      cmdValid <= 1'b0;
      outValid <= 1'b0;
      rxHold   <= 1'b0;
      inDone   <= 1'b0;
    end else begin
      inDone <= in_request;
      case (state)
        IDLE: begin
          if (pkt_start) begin
            if (accept && !pkt_err) begin
              cmdCode <= pkt_cmd;
              ovf     <= 1'b0;
              wrPtr   <= PW'(in_request);
              if (pkt_end) begin
                // Single-word packet: start and end share one cycle.
                cmdLen   <= LW'(in_request);
                cmdValid <= 1'b1;
                rxHold   <= 1'b1;
                state    <= DISPATCH_HDR;
              end else begin
                state <= COLLECT;
              end
            end else if (!accept && !pkt_end && !pkt_err) begin
              state <= DROP;
            end
          end else if (pkt_end && accept) begin
            cmdCode  <= pkt_cmd;
            cmdLen   <= '0;
            cmdValid <= 1'b1;
            rxHold   <= 1'b1;
            state    <= DISPATCH_HDR;
          end
        end
        COLLECT: begin
          if (storeWord) begin
            wrPtr <= wrPtr + PW'(1);
          end else if (in_request) begin
            ovf <= 1'b1;
          end
          if (pkt_err) begin
            state <= IDLE;
          end else if (pkt_end) begin
            if (collectOvf) begin
              state <= IDLE;
            end else begin
              cmdLen   <= collectLen;
              cmdValid <= 1'b1;
              rxHold   <= 1'b1;
              state    <= DISPATCH_HDR;
            end
          end
        end
        DROP: begin
          if (pkt_err || pkt_end) state <= IDLE;
        end
        DISPATCH_HDR: begin
          if (cmd_ready) begin
            cmdValid <= 1'b0;
            rdPtr    <= '0;
            if (cmdLen == '0) begin
              rxHold <= 1'b0;
              state  <= IDLE;
            end else begin
              outValid <= 1'b1;
              state    <= DISPATCH_DATA;
            end
          end
        end
        DISPATCH_DATA: begin
          if (out_ready) begin
            if (lastBeat) begin
              outValid <= 1'b0;
              rxHold   <= 1'b0;
              state    <= IDLE;
            end else begin
              rdPtr <= rdPtr + PW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_done   = inDone;
  assign rx_hold   = rxHold;
  assign cmd_valid = cmdValid;
  assign cmd_code  = cmdCode;
  assign cmd_len   = cmdLen;
  assign out_valid = outValid;
  assign out_data  = outValid ? rdData : '0;
  assign out_last  = outValid && lastBeat;

`ifdef SP_DISPATCH_STATS_EN
  logic        okEvt;
  logic        errEvt;
  logic        dropEvt;
  logic [15:0] okCnt;
  logic [15:0] errCnt;
  logic [15:0] dropCnt;

  // One-cycle packet outcome events, mirroring the FSM transitions above.
  always_comb begin
    okEvt   = 1'b0;
    errEvt  = 1'b0;
    dropEvt = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_start) begin
          if (pkt_err)                 errEvt  = 1'b1;
          else if (!accept && pkt_end) dropEvt = 1'b1;
        end
      end
      COLLECT: begin
        if (pkt_err)                    errEvt  = 1'b1;
        else if (pkt_end && collectOvf) dropEvt = 1'b1;
      end
      DROP: begin
        if (pkt_err)      errEvt  = 1'b1;
        else if (pkt_end) dropEvt = 1'b1;
      end
      DISPATCH_HDR: begin
        okEvt   = cmd_ready && (cmdLen == '0);
        dropEvt = pkt_start;
      end
      DISPATCH_DATA: begin
        okEvt   = out_ready && lastBeat;
        dropEvt = pkt_start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      okCnt   <= '0;
      errCnt  <= '0;
      dropCnt <= '0;
    end else begin
      if (okEvt && okCnt != 16'hFFFF)     okCnt   <= okCnt + 16'd1;
      if (errEvt && errCnt != 16'hFFFF)   errCnt  <= errCnt + 16'd1;
      if (dropEvt && dropCnt != 16'hFFFF) dropCnt <= dropCnt + 16'd1;
    end
  end

  assign stat_ok   = okCnt;
  assign stat_err  = errCnt;
  assign stat_drop = dropCnt;
`else
  assign stat_ok   = 16'h0;
  assign stat_err  = 16'h0;
  assign stat_drop = 16'h0;
`endif

endmodule
